// File: rtl/fmpad_pkg.sv
// fmpad_pkg: shared FSM state type, runtime pad-count width and counter sizing helper.
package fmpad_pkg;

    typedef enum logic [1:0] {S_LEFT, S_BODY, S_RIGHT} fmpad_state_e;

    localparam int PAD_CNT_W = 16;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    function automatic int cnt_width(input int in_len, input int pad_left, input int pad_right);
        return $clog2(max2(in_len, max2(pad_left, pad_right)) + 1);
    endfunction

endpackage

// File: rtl/fmpad_skid_buffer.sv
// fmpad_skid_buffer: 2-entry skid with registered output and registered has_room,
// so the upstream ready never depends combinationally on out_ready.
module fmpad_skid_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             has_room,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;

    assign has_room = !skid_valid;
    assign in_fire  = in_valid && has_room;

    // The skid entry only fills while the output register is stalled.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            out_valid  <= skid_valid || in_fire;
            out_data   <= skid_valid ? skid_data : in_fire ? in_data : out_data;
            skid_valid <= 1'b0;
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/fmpad_1d_stream.sv
// fmpad_1d_stream: zero-pads a channel-folded 1D feature-map stream with PAD_LEFT/PAD_RIGHT pixels per frame.
// Optional FMPAD_RUNTIME_CFG_EN adds runtime pad lengths applied at frame boundaries.
module fmpad_1d_stream
    import fmpad_pkg::*;
#(
    parameter int BIT_WIDTH    = 8,
    parameter int SIMD         = 2,
    parameter int NUM_CHANNELS = 2,
    parameter int IN_LEN       = 1024,
    parameter int PAD_LEFT     = 1,
    parameter int PAD_RIGHT    = 1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in0_V_TVALID,
    output logic                      in0_V_TREADY,
    input  logic [BIT_WIDTH*SIMD-1:0] in0_V_TDATA,
    output logic                      out_V_TVALID,
    input  logic                      out_V_TREADY,
    output logic [BIT_WIDTH*SIMD-1:0] out_V_TDATA
`ifdef FMPAD_RUNTIME_CFG_EN
    ,
    input  logic [PAD_CNT_W-1:0]      cfg_pad_left,
    input  logic [PAD_CNT_W-1:0]      cfg_pad_right,
    input  logic                      cfg_valid
`endif
);

    localparam int DW     = BIT_WIDTH * SIMD;
    localparam int CF     = NUM_CHANNELS / SIMD;
    localparam int FW     = CF > 1 ? $clog2(CF) : 1;
    localparam int BASE_W = cnt_width(IN_LEN, PAD_LEFT, PAD_RIGHT);
`ifdef FMPAD_RUNTIME_CFG_EN
    localparam int CNT_W  = BASE_W > PAD_CNT_W ? BASE_W : PAD_CNT_W;
`else
    localparam int CNT_W  = BASE_W;
`endif

    if (NUM_CHANNELS % SIMD != 0 || CF < 1) begin : g_bad_fold
        $error("fmpad_1d_stream: NUM_CHANNELS must be a non-zero multiple of SIMD");
    end
    if (IN_LEN < 1 || PAD_LEFT < 0 || PAD_RIGHT < 0) begin : g_bad_len
        $error("fmpad_1d_stream: IN_LEN must be >= 1 and pads >= 0");
    end

    fmpad_state_e     state, state_nxt, first_region;
    logic [FW-1:0]    fold_cnt, fold_nxt;
    logic [CNT_W-1:0] pix_cnt, pix_nxt, region_last;
    logic [CNT_W-1:0] pad_left, pad_right, nxt_left;
    logic             has_room, gen_valid, gen_fire, fold_last;
    logic             region_end, frame_end, at_boundary;
    logic [DW-1:0]    gen_data;

`ifdef FMPAD_RUNTIME_CFG_EN
    logic [CNT_W-1:0] sh_left, sh_right;

    // Shadow regs catch cfg at any time; active regs only move between frames.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            pad_left  <= CNT_W'(PAD_LEFT);
            pad_right <= CNT_W'(PAD_RIGHT);
            sh_left   <= CNT_W'(PAD_LEFT);
            sh_right  <= CNT_W'(PAD_RIGHT);
        end else begin
            if (cfg_valid) begin
                sh_left  <= CNT_W'(cfg_pad_left);
                sh_right <= CNT_W'(cfg_pad_right);
            end
            if (frame_end || at_boundary) begin
                pad_left  <= sh_left;
                pad_right <= sh_right;
            end
        end
    end

    assign nxt_left = sh_left;
`else
    assign pad_left  = CNT_W'(PAD_LEFT);
    assign pad_right = CNT_W'(PAD_RIGHT);
    assign nxt_left  = pad_left;
`endif

    always_comb begin
        gen_valid    = state != S_BODY || in0_V_TVALID;
        gen_fire     = gen_valid && has_room;
        gen_data     = state == S_BODY ? in0_V_TDATA : '0;
        fold_last    = fold_cnt == FW'(CF - 1);
        region_last  = state == S_LEFT ? pad_left - 1'b1 :
                       state == S_RIGHT ? pad_right - 1'b1 : CNT_W'(IN_LEN - 1);
        region_end   = gen_fire && fold_last && pix_cnt == region_last;
        frame_end    = region_end && (state == S_RIGHT || (state == S_BODY && pad_right == '0));
        // Start of a frame with nothing produced yet: safe point to adopt new pad lengths.
        at_boundary  = !gen_fire && pix_cnt == '0 && fold_cnt == '0 &&
                       state == (pad_left != '0 ? S_LEFT : S_BODY);
        first_region = nxt_left != '0 ? S_LEFT : S_BODY;
        fold_nxt     = !gen_fire ? fold_cnt : fold_last ? '0 : fold_cnt + 1'b1;
        pix_nxt      = !(gen_fire && fold_last) ? pix_cnt : region_end ? '0 : pix_cnt + 1'b1;
        state_nxt    = !region_end ? (at_boundary ? first_region : state) :
                       state == S_LEFT ? S_BODY :
                       (state == S_BODY && pad_right != '0) ? S_RIGHT : first_region;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= PAD_LEFT != 0 ? S_LEFT : S_BODY;
            fold_cnt <= '0;
            pix_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            fold_cnt <= fold_nxt;
            pix_cnt  <= pix_nxt;
        end
    end

    assign in0_V_TREADY = !ap_rst && state == S_BODY && has_room;

    fmpad_skid_buffer #(.WIDTH(DW)) u_skid (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .in_valid (gen_valid),
        .in_data  (gen_data),
        .has_room (has_room),
        .out_valid(out_V_TVALID),
        .out_ready(out_V_TREADY),
        .out_data (out_V_TDATA)
    );

endmodule

// File: tb/tb_fmpad_1d_stream.sv
// tb_fmpad_1d_stream: scoreboard bench over three configs (CF=1 pads 1/2, CF=2 pads 1/1, passthrough).
module tb_fmpad_1d_stream;

    logic        clk;
    logic        rst[3];
    logic        in_vld[3], in_rdy[3], out_vld[3], out_rdy[3];
    logic [15:0] in_dat[3], out_dat[3];
    logic [15:0] q0[$], q1[$], q2[$];
    int          checks = 0, errors = 0, bubbles, acc;
    logic        stall[3];
    logic [15:0] stall_dat[3];
    logic        have, fire_c;
    logic [15:0] exp_v;
`ifdef FMPAD_RUNTIME_CFG_EN
    logic [15:0] cfg_l, cfg_r;
    logic        cfg_v;
`endif

    fmpad_1d_stream #(.NUM_CHANNELS(2), .SIMD(2), .IN_LEN(4), .PAD_LEFT(1), .PAD_RIGHT(2)) u_a (
        .ap_clk(clk), .ap_rst(rst[0]),
        .in0_V_TVALID(in_vld[0]), .in0_V_TREADY(in_rdy[0]), .in0_V_TDATA(in_dat[0]),
        .out_V_TVALID(out_vld[0]), .out_V_TREADY(out_rdy[0]), .out_V_TDATA(out_dat[0])
`ifdef FMPAD_RUNTIME_CFG_EN
        , .cfg_pad_left(cfg_l), .cfg_pad_right(cfg_r), .cfg_valid(cfg_v)
`endif
    );

    fmpad_1d_stream #(.NUM_CHANNELS(4), .SIMD(2), .IN_LEN(2), .PAD_LEFT(1), .PAD_RIGHT(1)) u_b (
        .ap_clk(clk), .ap_rst(rst[1]),
        .in0_V_TVALID(in_vld[1]), .in0_V_TREADY(in_rdy[1]), .in0_V_TDATA(in_dat[1]),
        .out_V_TVALID(out_vld[1]), .out_V_TREADY(out_rdy[1]), .out_V_TDATA(out_dat[1])
`ifdef FMPAD_RUNTIME_CFG_EN
        , .cfg_pad_left(16'd0), .cfg_pad_right(16'd0), .cfg_valid(1'b0)
`endif
    );

    fmpad_1d_stream #(.NUM_CHANNELS(2), .SIMD(2), .IN_LEN(4), .PAD_LEFT(0), .PAD_RIGHT(0)) u_c (
        .ap_clk(clk), .ap_rst(rst[2]),
        .in0_V_TVALID(in_vld[2]), .in0_V_TREADY(in_rdy[2]), .in0_V_TDATA(in_dat[2]),
        .out_V_TVALID(out_vld[2]), .out_V_TREADY(out_rdy[2]), .out_V_TDATA(out_dat[2])
`ifdef FMPAD_RUNTIME_CFG_EN
        , .cfg_pad_left(16'd0), .cfg_pad_right(16'd0), .cfg_valid(1'b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int qsz(input int k);
        return k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
    endfunction

    function automatic logic [15:0] qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic push(input int k, input logic [15:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    // Body beats, then right-pad beats, then the next frame's left-pad beats (all counts in beats).
    task automatic push_frame(input int k, input int n, input logic [15:0] base, input int nr, input int nl);
        for (int i = 0; i < n; i++) push(k, 16'(base + i));
        repeat (nr + nl) push(k, 16'd0);
    endtask

    // Output scoreboard and stall-stability check, sampled on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) stall[k] <= 1'b0;
            else begin
                if (stall[k]) begin
                    checks++;
                    assert ({out_vld[k], out_dat[k]} === {1'b1, stall_dat[k]}) else begin
                        errors++;
                        $error("FAIL hold%0d: got vld=%0b data=%h want vld=1 data=%h", k, out_vld[k], out_dat[k], stall_dat[k]);
                    end
                end
                stall[k]     <= out_vld[k] && !out_rdy[k];
                stall_dat[k] <= out_dat[k];
                if (out_vld[k] && out_rdy[k]) begin
                    have  = qsz(k) != 0;
                    exp_v = have ? qpop(k) : 16'd0;
                    checks++;
                    assert (have && out_dat[k] === exp_v) else begin
                        errors++;
                        $error("FAIL out%0d: got %h want %h (expected beat pending=%0b)", k, out_dat[k], exp_v, have);
                    end
                end
            end
        end
    end

    task automatic send(input int k, input int n, input logic [15:0] base, input bit rnd);
        int   idx = 0;
        int   budget = 0;
        logic fire;
        in_dat[k]  = base;
        in_vld[k]  = 1'b1;
        out_rdy[k] = rnd ? 1'($urandom_range(1)) : 1'b1;
        while (idx < n && budget < 1000) begin
            @(negedge clk);
            fire = in_vld[k] && in_rdy[k];
            @(posedge clk);
            #1;
            budget++;
            if (fire) idx++;
            in_dat[k] = 16'(base + idx);
            in_vld[k] = idx < n && ((in_vld[k] && !fire) || !rnd || $urandom_range(3) != 0);
            if (rnd) out_rdy[k] = 1'($urandom_range(1));
        end
        checks++;
        assert (idx == n) else begin
            errors++;
            $error("FAIL send%0d: accepted %0d beats want %0d", k, idx, n);
        end
    endtask

    task automatic drain(input int k);
        int b = 0;
        out_rdy[k] = 1'b1;
        in_vld[k]  = 1'b0;
        while (qsz(k) != 0 && b < 500) begin
            @(posedge clk);
            #1;
            b++;
        end
        checks++;
        assert (qsz(k) == 0) else begin
            errors++;
            $error("FAIL drain%0d: %0d beats outstanding want 0", k, qsz(k));
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]     = 1'b1;
            in_vld[k]  = 1'b0;
            in_dat[k]  = 16'd0;
            out_rdy[k] = 1'b1;
        end
`ifdef FMPAD_RUNTIME_CFG_EN
        cfg_l = 16'd0;
        cfg_r = 16'd0;
        cfg_v = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            assert ({out_vld[k], in_rdy[k], out_dat[k]} === 18'd0) else begin
                errors++;
                $error("FAIL reset%0d: got vld=%0b rdy=%0b data=%h want 0/0/0000", k, out_vld[k], in_rdy[k], out_dat[k]);
            end
        end

        // Release: A streams three frames back to back, B emits its left pad.
        @(posedge clk);
        #1;
        push(0, 16'd0);
        for (int f = 0; f < 3; f++) push_frame(0, 4, 16'd1, 2, 1);
        push(1, 16'd0);
        push(1, 16'd0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) send(0, 4, 16'd1, 1'b0);
            end
            begin
                @(negedge clk);
                checks++;
                assert (out_vld[0] === 1'b0) else begin
                    errors++;
                    $error("FAIL lat0: got vld=%0b want 0", out_vld[0]);
                end
                @(negedge clk);
                checks++;
                assert (out_vld[0] === 1'b1) else begin
                    errors++;
                    $error("FAIL lat1: got vld=%0b want 1", out_vld[0]);
                end
                bubbles = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (!out_vld[0]) bubbles++;
                end
                checks++;
                assert (bubbles == 0) else begin
                    errors++;
                    $error("FAIL bubbles: got %0d idle cycles want 0", bubbles);
                end
            end
        join
        drain(0);

        // B: folded pixels (A0,A1),(B0,B1), then three frames with gaps and random ready.
        push_frame(1, 4, 16'h00A0, 2, 2);
        send(1, 4, 16'h00A0, 1'b0);
        drain(1);
        for (int f = 0; f < 3; f++) push_frame(1, 4, 16'(16'h0100 * (f + 1)), 2, 2);
        for (int f = 0; f < 3; f++) send(1, 4, 16'(16'h0100 * (f + 1)), 1'b1);
        drain(1);

        // C: passthrough with a blocked output fills exactly two skid entries.
        push_frame(2, 4, 16'd10, 0, 0);
        out_rdy[2] = 1'b0;
        in_vld[2]  = 1'b1;
        in_dat[2]  = 16'd10;
        acc = 0;
        repeat (6) begin
            @(negedge clk);
            fire_c = in_vld[2] && in_rdy[2];
            @(posedge clk);
            #1;
            if (fire_c) acc++;
            in_dat[2] = 16'(10 + acc);
        end
        checks++;
        assert (acc == 2 && in_rdy[2] === 1'b0) else begin
            errors++;
            $error("FAIL skidfull: got accepted=%0d rdy=%0b want 2/0", acc, in_rdy[2]);
        end
        send(2, 2, 16'd12, 1'b0);
        drain(2);

        // A: reset after two body beats, then a full frame from the left pad.
        push(0, 16'd5);
        push(0, 16'd6);
        in_vld[0] = 1'b1;
        in_dat[0] = 16'd5;
        @(posedge clk);
        #1;
        in_dat[0] = 16'd6;
        @(posedge clk);
        #1;
        rst[0]    = 1'b1;
        in_vld[0] = 1'b0;
        @(negedge clk);
        checks++;
        assert (in_rdy[0] === 1'b0) else begin
            errors++;
            $error("FAIL rstrdy: got rdy=%0b want 0", in_rdy[0]);
        end
        @(negedge clk);
        checks++;
        assert (out_vld[0] === 1'b0) else begin
            errors++;
            $error("FAIL rstvld: got vld=%0b want 0", out_vld[0]);
        end
        q0.delete();
        push(0, 16'd0);
        push_frame(0, 4, 16'd1, 2, 1);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        send(0, 4, 16'd1, 1'b0);
        drain(0);

`ifdef FMPAD_RUNTIME_CFG_EN
        // New pads arrive mid-frame; the current frame keeps (1,2), the next uses (3,0).
        cfg_l = 16'd3;
        cfg_r = 16'd0;
        cfg_v = 1'b1;
        @(posedge clk);
        #1;
        cfg_v = 1'b0;
        push_frame(0, 4, 16'd21, 2, 3);
        push_frame(0, 4, 16'd31, 0, 3);
        send(0, 4, 16'd21, 1'b0);
        send(0, 4, 16'd31, 1'b0);
        drain(0);
`endif

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
